test_exit_monitor: RTL and testbench
====================================

// Module: test_exit_monitor
// PURPOSE
//  Harness-side completion detector that generates io_success for the top-level test driver.
//  - Watches per-hart tohost-style exit writes and per-hart retire heartbeats.
//  - Reports PASS when every hart exits with code 0.
//  - Reports FAIL on any nonzero exit code or on a no-progress watchdog timeout.
//  - Outputs are registered and sticky until reset, so the driver samples them on any later edge.
// PARAMETERS
//  NUM_HARTS  1   number of harts monitored
//  CODE_W     32  width of one exit-write data word
//  WDOG_W     32  width of the watchdog counter and of io_wdog_limit
//  HOLDOFF    16  cycles after reset deassertion during which all inputs are ignored (1..255)
// PORTS
//  clock          in   1                   single clock domain
//  reset          in   1                   asynchronous, active-high
//  io_exit_valid  in   NUM_HARTS           per-hart exit write strobe, one cycle per write
//  io_exit_data   in   NUM_HARTS*CODE_W    hart h data at [h*CODE_W +: CODE_W]; bit0=1 marks an exit, code = data[CODE_W-1:1]
//  io_heartbeat   in   NUM_HARTS           per-hart instruction-retire pulse
//  io_wdog_limit  in   WDOG_W              watchdog limit in cycles; 0 disables; quasi-static
//  io_success     out  1                   PASS indication, sticky
//  io_failure     out  1                   FAIL indication, sticky
//  io_timeout     out  1                   FAIL caused by the watchdog
//  io_exit_code   out  CODE_W-1            code of the failing exit; all-ones on timeout
//  io_fail_hart   out  max(1,$clog2(NUM_HARTS))  index of the failing hart; 0 on timeout
// BEHAVIOUR
//  Reset
//  - Async assert clears all outputs, done mask, watchdog count and holdoff counter to 0.
//  - State goes to S_HOLDOFF. Reset asserted mid-run aborts immediately; no state survives.
//  States (S_HOLDOFF, S_RUN, S_PASS, S_FAIL)
//  - S_HOLDOFF: count HOLDOFF cycles, then enter S_RUN. All inputs are ignored; the watchdog is idle.
//  - S_RUN: evaluate each cycle. Only writes with valid=1 and data bit0=1 count as exits; bit0=0 writes are ignored.
//  - S_RUN exit, code==0: set done[h].
//  - S_RUN exit, code!=0: go to S_FAIL. Record code and hart h.
//  - S_RUN, more than one failing hart in the same cycle: the lowest index is recorded.
//  - S_RUN, a second exit from an already-done hart is evaluated the same way (code 0 is a no-op; nonzero fails).
//  - S_RUN, done mask (including this cycle's exits) all-ones and no failure this cycle: go to S_PASS.
//  - S_PASS, S_FAIL: absorbing. All inputs are ignored until reset.
//  Priority within one S_RUN cycle
//  - Nonzero exit > all-done PASS > watchdog timeout.
//  - An exit that completes the mask in the same cycle the watchdog expires yields PASS.
//  Latency
//  - An exit in cycle n drives io_success/io_failure high at the edge ending cycle n, i.e. visible in cycle n+1.
//  - Exactly one of io_success and io_failure is ever set.
//  Watchdog
//  - Counter clears on any heartbeat bit. Otherwise it increments, saturating at all-ones.
//  - When limit!=0 and count+1 == limit with no heartbeat in that cycle: go to S_FAIL.
//  - On timeout: io_timeout=1, io_exit_code=all-ones, io_fail_hart=0.
//  - limit==0: never fires. The counter still runs and saturates.
//  - The watchdog runs only in S_RUN; it holds at 0 in the other states.
// STRUCTURE
//  Package test_exit_pkg
//  - state_e enum: S_HOLDOFF, S_RUN, S_PASS, S_FAIL (2-bit).
//  - EXIT_FLAG_BIT = 0.
//  - function exit_code_timeout(CODE_W) returning all-ones.
//  Sub-module exit_watchdog (WDOG_W)
//  - Inputs: clock, reset, enable, kick, limit. Output: expire.
//  - Owns the saturating counter.
//  Top level
//  - FSM, holdoff counter, done mask, lowest-index failure priority encoder, output registers.
// TESTING
//  - NUM_HARTS=2, limit=0: hart0 writes 0x1 at cycle 30, hart1 writes 0x1 at cycle 40 -> io_success=1 from cycle 41; io_failure stays 0.
//  - Hart1 writes 0x7 (code 3) at cycle 30 -> io_failure=1, io_exit_code=3, io_fail_hart=1 from cycle 31; a later 0x1 from hart0 changes nothing.
//  - Both harts write 0x5 and 0x9 in the same cycle -> io_fail_hart=0, io_exit_code=2.
//  - limit=100, no heartbeats after holdoff -> io_failure=1, io_timeout=1, io_exit_code=all-ones exactly 100 cycles after entering S_RUN.
//  - Heartbeat every 50 cycles with limit=100 -> no timeout over 10k cycles.
//  - Exit 0x1 during holdoff cycle 5 -> ignored, done mask stays 0.
//  - Reset pulsed after PASS -> all outputs 0 asynchronously; the PASS sequence repeats identically.

Source files
------------

// File: rtl/test_exit_pkg.sv
// Shared types and constants for the test exit monitor.
package test_exit_pkg;

  typedef enum logic [1:0] {
    S_HOLDOFF,
    S_RUN,
    S_PASS,
    S_FAIL
  } state_e;

  localparam int unsigned EXIT_FLAG_BIT   = 0;
  localparam int unsigned EXIT_CODE_MAX_W = 64;

  // Timeout code is all-ones over the code_w-1 code bits of an exit word.
  function automatic logic [EXIT_CODE_MAX_W-1:0] exit_code_timeout(input int unsigned code_w);
    logic [EXIT_CODE_MAX_W-1:0] r;
    r = '0;
    for (int unsigned i = 0; i < EXIT_CODE_MAX_W; i++) begin
      if (i + 1 < code_w) r[i] = 1'b1;
    end
    return r;
  endfunction

endpackage

// File: rtl/test_exit_monitor_if.sv
// Harness-to-monitor signal bundle: exit writes and heartbeats in, verdict out.
interface test_exit_monitor_if #(
  parameter int unsigned NUM_HARTS = 1,
  parameter int unsigned CODE_W    = 32,
  parameter int unsigned WDOG_W    = 32
);
  localparam int unsigned HartW = (NUM_HARTS > 1) ? $clog2(NUM_HARTS) : 1;

  logic [NUM_HARTS-1:0]        io_exit_valid;
  logic [NUM_HARTS*CODE_W-1:0] io_exit_data;
  logic [NUM_HARTS-1:0]        io_heartbeat;
  logic [WDOG_W-1:0]           io_wdog_limit;
  logic                        io_success;
  logic                        io_failure;
  logic                        io_timeout;
  logic [CODE_W-2:0]           io_exit_code;
  logic [HartW-1:0]            io_fail_hart;

  modport master (
    output io_exit_valid, io_exit_data, io_heartbeat, io_wdog_limit,
    input  io_success, io_failure, io_timeout, io_exit_code, io_fail_hart
  );

  modport slave (
    input  io_exit_valid, io_exit_data, io_heartbeat, io_wdog_limit,
    output io_success, io_failure, io_timeout, io_exit_code, io_fail_hart
  );

endinterface

// File: rtl/exit_watchdog.sv
// No-progress watchdog: saturating cycle counter cleared by any heartbeat.
module exit_watchdog #(
  parameter int unsigned WDOG_W = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              enable,
  input  logic              kick,
  input  logic [WDOG_W-1:0] limit,
  output logic              expire
);

  logic [WDOG_W-1:0] count_q, count_d, count_inc;

  assign count_inc = count_q + WDOG_W'(1);

  always_comb begin
    count_d = count_q;
    if (!enable || kick) begin
      count_d = '0;
    end else if (count_q != '1) begin
      count_d = count_inc;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) count_q <= '0;
    else       count_q <= count_d;
  end

  // A zero limit disables expiry; the counter itself keeps running.
  assign expire = enable && !kick && (limit != '0) && (count_inc == limit);

endmodule

// File: rtl/test_exit_monitor.sv
// Completion detector: sticky PASS when all harts exit with 0, sticky FAIL on bad exit or stall.
module test_exit_monitor
  import test_exit_pkg::*;
#(
  parameter int unsigned NUM_HARTS = 1,
  parameter int unsigned CODE_W    = 32,
  parameter int unsigned WDOG_W    = 32,
  parameter int unsigned HOLDOFF   = 16
) (
  input logic           clock,
  input logic           reset,
  test_exit_monitor_if.slave io
);

  localparam int unsigned HartW = (NUM_HARTS > 1) ? $clog2(NUM_HARTS) : 1;
  localparam logic [EXIT_CODE_MAX_W-1:0] TimeoutFull = exit_code_timeout(CODE_W);
  localparam logic [CODE_W-2:0] TimeoutCode = TimeoutFull[CODE_W-2:0];

  state_e               state_q, state_d;
  logic [7:0]           holdoff_q, holdoff_d;
  logic [NUM_HARTS-1:0] done_q, done_d;
  logic                 success_q, success_d;
  logic                 failure_q, failure_d;
  logic                 timeout_q, timeout_d;
  logic [CODE_W-2:0]    code_q, code_d;
  logic [HartW-1:0]     hart_q, hart_d;

  logic [NUM_HARTS-1:0] exit_ok;
  logic                 fail_hit;
  logic [CODE_W-2:0]    fail_code;
  logic [HartW-1:0]     fail_idx;
  logic                 all_done;
  logic                 run;
  logic                 wdog_expire;

  assign run = (state_q == S_RUN);

  exit_watchdog #(
    .WDOG_W (WDOG_W)
  ) u_wdog (
    .clock  (clock),
    .reset  (reset),
    .enable (run),
    .kick   (|io.io_heartbeat),
    .limit  (io.io_wdog_limit),
    .expire (wdog_expire)
  );

  // Descending scan so the lowest failing hart is the one that sticks.
  always_comb begin
    exit_ok   = '0;
    fail_hit  = 1'b0;
    fail_code = '0;
    fail_idx  = '0;
    for (int h = NUM_HARTS - 1; h >= 0; h--) begin
      if (io.io_exit_valid[h] && io.io_exit_data[h*CODE_W + EXIT_FLAG_BIT]) begin
        if (io.io_exit_data[h*CODE_W + 1 +: CODE_W-1] == '0) begin
          exit_ok[h] = 1'b1;
        end else begin
          fail_hit  = 1'b1;
          fail_code = io.io_exit_data[h*CODE_W + 1 +: CODE_W-1];
          fail_idx  = HartW'(h);
        end
      end
    end
  end

  assign all_done = &(done_q | exit_ok);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= S_HOLDOFF;
      holdoff_q <= '0;
      done_q    <= '0;
      success_q <= 1'b0;
      failure_q <= 1'b0;
      timeout_q <= 1'b0;
      code_q    <= '0;
      hart_q    <= '0;
    end else begin
      state_q   <= state_d;
      holdoff_q <= holdoff_d;
      done_q    <= done_d;
      success_q <= success_d;
      failure_q <= failure_d;
      timeout_q <= timeout_d;
      code_q    <= code_d;
      hart_q    <= hart_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_HOLDOFF: if (holdoff_q == 8'(HOLDOFF - 1)) state_d = S_RUN;
      S_RUN: begin
        if (fail_hit)         state_d = S_FAIL;
        else if (all_done)    state_d = S_PASS;
        else if (wdog_expire) state_d = S_FAIL;
      end
      S_PASS, S_FAIL: state_d = state_q;
    endcase
  end

  always_comb begin
    holdoff_d = holdoff_q;
    done_d    = done_q;
    success_d = success_q;
    failure_d = failure_q;
    timeout_d = timeout_q;
    code_d    = code_q;
    hart_d    = hart_q;
    if (state_q == S_HOLDOFF) holdoff_d = holdoff_q + 8'd1;
    if (run) begin
      done_d = done_q | exit_ok;
      if (fail_hit) begin
        failure_d = 1'b1;
        code_d    = fail_code;
        hart_d    = fail_idx;
      end else if (all_done) begin
        success_d = 1'b1;
      end else if (wdog_expire) begin
        failure_d = 1'b1;
        timeout_d = 1'b1;
        code_d    = TimeoutCode;
        hart_d    = '0;
      end
    end
  end

  assign io.io_success   = success_q;
  assign io.io_failure   = failure_q;
  assign io.io_timeout   = timeout_q;
  assign io.io_exit_code = code_q;
  assign io.io_fail_hart = hart_q;

endmodule

// File: tb/tb_test_exit_monitor.sv
// Scoreboard bench for test_exit_monitor with two harts and default holdoff.
module tb_test_exit_monitor;

  localparam int unsigned NH = 2;
  localparam int unsigned CW = 32;
  localparam int unsigned WW = 32;

  typedef struct {
    int unsigned at;
    string       tag;
    logic        succ;
    logic        fail;
    logic        tmo;
    logic [30:0] code;
    logic        hart;
  } exp_t;

  logic        clock;
  logic        reset;
  int unsigned cyc;
  int unsigned n_checks;
  int unsigned n_fail;
  exp_t        sb[$];

  test_exit_monitor_if #(.NUM_HARTS(NH), .CODE_W(CW), .WDOG_W(WW)) intf ();

  test_exit_monitor #(
    .NUM_HARTS (NH),
    .CODE_W    (CW),
    .WDOG_W    (WW),
    .HOLDOFF   (16)
  ) dut (
    .clock (clock),
    .reset (reset),
    .io    (intf.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #2_000_000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1);
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic push_exp(input string tag, input int unsigned at, input logic s, input logic f,
                          input logic t, input logic [30:0] c, input logic h);
    exp_t e;
    e.at = at; e.tag = tag; e.succ = s; e.fail = f; e.tmo = t; e.code = c; e.hart = h;
    sb.push_back(e);
  endtask

  task automatic sb_check();
    int i;
    exp_t e;
    i = 0;
    while (i < sb.size()) begin
      if (sb[i].at == cyc) begin
        e = sb[i];
        check_eq({e.tag, "_succ"}, 64'(intf.io_success),   64'(e.succ));
        check_eq({e.tag, "_fail"}, 64'(intf.io_failure),   64'(e.fail));
        check_eq({e.tag, "_tmo"},  64'(intf.io_timeout),   64'(e.tmo));
        check_eq({e.tag, "_code"}, 64'(intf.io_exit_code), 64'(e.code));
        check_eq({e.tag, "_hart"}, 64'(intf.io_fail_hart), 64'(e.hart));
        sb.delete(i);
      end else begin
        i++;
      end
    end
  endtask

  task automatic sb_drain();
    if (sb.size() != 0) begin
      check_eq("sb_drain", 64'(sb.size()), 64'd0);
      sb.delete();
    end
  endtask

  task automatic tick();
    @(negedge clock);
    sb_check();
    @(posedge clock);
    #1;
    intf.io_exit_valid = '0;
    intf.io_exit_data  = '0;
    intf.io_heartbeat  = '0;
    cyc++;
  endtask

  task automatic run_to(input int unsigned n);
    while (cyc < n) tick();
  endtask

  task automatic exit_wr(input int h, input logic [31:0] d);
    intf.io_exit_valid[h]       = 1'b1;
    intf.io_exit_data[h*32 +: 32] = d;
  endtask

  // Reset is checked asynchronously, before any clock edge sees it.
  task automatic do_reset();
    reset = 1'b1;
    #1;
    check_eq("rst_succ", 64'(intf.io_success),   64'd0);
    check_eq("rst_fail", 64'(intf.io_failure),   64'd0);
    check_eq("rst_tmo",  64'(intf.io_timeout),   64'd0);
    check_eq("rst_code", 64'(intf.io_exit_code), 64'd0);
    check_eq("rst_hart", 64'(intf.io_fail_hart), 64'd0);
    @(posedge clock);
    #1;
    intf.io_exit_valid = '0;
    intf.io_exit_data  = '0;
    intf.io_heartbeat  = '0;
    reset = 1'b0;
    cyc   = 0;
  endtask

  task automatic run_pass(input string tag);
    intf.io_wdog_limit = '0;
    do_reset();
    run_to(30);
    exit_wr(0, 32'h1);
    push_exp({tag, "_half"}, 31, 1'b0, 1'b0, 1'b0, 31'd0, 1'b0);
    tick();
    run_to(40);
    exit_wr(1, 32'h1);
    push_exp({tag, "_pre"},    40, 1'b0, 1'b0, 1'b0, 31'd0, 1'b0);
    push_exp({tag, "_done"},   41, 1'b1, 1'b0, 1'b0, 31'd0, 1'b0);
    push_exp({tag, "_sticky"}, 60, 1'b1, 1'b0, 1'b0, 31'd0, 1'b0);
    tick();
    run_to(61);
    sb_drain();
  endtask

  initial begin
    reset = 1'b1;
    cyc = 0; n_checks = 0; n_fail = 0;
    intf.io_exit_valid = '0;
    intf.io_exit_data  = '0;
    intf.io_heartbeat  = '0;
    intf.io_wdog_limit = '0;

    // PASS, then an async reset out of PASS and the identical sequence again.
    run_pass("pass1");
    run_pass("pass2");

    // Single failing exit; later good exit must not disturb it.
    do_reset();
    run_to(30);
    exit_wr(1, 32'h7);
    push_exp("fail", 31, 1'b0, 1'b1, 1'b0, 31'd3, 1'b1);
    tick();
    run_to(35);
    exit_wr(0, 32'h1);
    push_exp("fail_hold", 36, 1'b0, 1'b1, 1'b0, 31'd3, 1'b1);
    tick();
    run_to(40);
    sb_drain();

    // Two failing harts in one cycle: lowest index wins.
    do_reset();
    run_to(30);
    exit_wr(0, 32'h5);
    exit_wr(1, 32'h9);
    push_exp("dual", 31, 1'b0, 1'b1, 1'b0, 31'd2, 1'b0);
    tick();
    run_to(35);
    sb_drain();

    // Re-exit of a done hart with nonzero code beats a mask-completing exit.
    do_reset();
    run_to(25);
    exit_wr(0, 32'h1);
    tick();
    run_to(30);
    exit_wr(0, 32'h3);
    exit_wr(1, 32'h1);
    push_exp("reexit", 31, 1'b0, 1'b1, 1'b0, 31'd1, 1'b0);
    tick();
    run_to(35);
    sb_drain();

    // Holdoff exits and flagless writes are ignored.
    do_reset();
    run_to(5);
    exit_wr(0, 32'h1);
    exit_wr(1, 32'h1);
    push_exp("hold", 17, 1'b0, 1'b0, 1'b0, 31'd0, 1'b0);
    tick();
    run_to(20);
    exit_wr(1, 32'h1);
    push_exp("hold_h1", 21, 1'b0, 1'b0, 1'b0, 31'd0, 1'b0);
    tick();
    run_to(22);
    exit_wr(0, 32'h2);
    push_exp("noflag", 23, 1'b0, 1'b0, 1'b0, 31'd0, 1'b0);
    tick();
    run_to(25);
    exit_wr(0, 32'h1);
    push_exp("hold_pass", 26, 1'b1, 1'b0, 1'b0, 31'd0, 1'b0);
    tick();
    run_to(30);
    sb_drain();

    // Watchdog expiry 100 cycles after run entry (cycle 16).
    intf.io_wdog_limit = 32'd100;
    do_reset();
    push_exp("tmo_pre", 115, 1'b0, 1'b0, 1'b0, 31'd0, 1'b0);
    push_exp("tmo",     116, 1'b0, 1'b1, 1'b1, 31'h7fff_ffff, 1'b0);
    run_to(120);
    sb_drain();

    // Mask completes in the very cycle the watchdog expires: PASS wins.
    do_reset();
    run_to(50);
    exit_wr(0, 32'h1);
    tick();
    run_to(115);
    exit_wr(1, 32'h1);
    push_exp("race", 116, 1'b1, 1'b0, 1'b0, 31'd0, 1'b0);
    tick();
    run_to(120);
    sb_drain();

    // Heartbeat every 50 cycles keeps the watchdog quiet for 10k cycles.
    do_reset();
    push_exp("hb50", 10000, 1'b0, 1'b0, 1'b0, 31'd0, 1'b0);
    while (cyc <= 10000) begin
      if (cyc % 50 == 0) intf.io_heartbeat = 2'b01;
      tick();
    end
    sb_drain();

    // Heartbeat exactly every 100 cycles lands on the expiry cycle and prevents it.
    do_reset();
    push_exp("hb100", 600, 1'b0, 1'b0, 1'b0, 31'd0, 1'b0);
    while (cyc <= 600) begin
      if (cyc % 100 == 0) intf.io_heartbeat = 2'b10;
      tick();
    end
    sb_drain();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
